score_display: RTL and testbench

Drives the board's 4-digit multiplexed seven-segment display from the 12-bit game score produced by the `score` block. The block does three things:

- Converts the binary score to four BCD digits with a sequential double-dabble engine.
- Holds the converted digits in a display register.
- Time-multiplexes the digits onto shared segment lines, blanking leading zeros.

It sits between `score` and the top-level display pins.

---
 rtl/score_display_if.sv | 10 +
 rtl/score_display.sv | 134 +++++++++++++
 tb/tb_score_display.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - score/BCD handshake bundle between score source and score_display
interface score_display_if;
   logic [11:0] score;
   logic        busy;
   logic        done;
   logic [15:0] bcd;

   modport master (output score, input busy, input done, input bcd);
   modport slave  (input score, output busy, output done, output bcd);
endinterface

// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to BCD conversion and 4-digit multiplexed seven-segment drive
module score_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic            clk,
   input  logic            rst_n,
   score_display_if.slave  bus,
   output logic [6:0]      seg,
   output logic [3:0]      an
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam int             RW   = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0]  RMAX = RW'(REFRESH_DIV - 1);

   logic [1:0]    state;
   logic [11:0]   bin;
   logic [11:0]   cap;
   logic [11:0]   shown;
   logic [15:0]   acc;
   logic [15:0]   corr;
   logic [3:0]    cnt;
   logic [15:0]   bcd_r;
   logic          done_r;
   logic          busy_r;
   logic [RW-1:0] rcnt;
   logic [1:0]    sel;
   logic [3:0]    nib;
   logic          blank;

   // Add-3 correction of every BCD nibble that would overflow past 9 after doubling
   always_comb begin
      corr = acc;
      for (int i = 0; i < 4; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            corr[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM: capture a changed score, run 12 double-dabble steps, publish the digits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         bin    <= '0;
         cap    <= '0;
         shown  <= '0;
         acc    <= '0;
         cnt    <= '0;
         bcd_r  <= '0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.score != shown) begin
                  bin    <= bus.score;
                  cap    <= bus.score;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= SHIFT;
                  busy_r <= 1'b1;
               end
            end
            SHIFT: begin
               // The top accumulator bit can never be set for a 12-bit input, so dropping it is safe
               {acc, bin} <= {corr, bin} << 1;
               cnt        <= cnt + 4'd1;
               if (cnt == 4'd11) begin
                  state <= DONE;
               end
            end
            DONE: begin
               bcd_r  <= acc;
               shown  <= cap;
               done_r <= 1'b1;
               state  <= IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Refresh timer: hold each digit for REFRESH_DIV cycles, then move to the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt <= '0;
         sel  <= 2'd0;
      end else if (rcnt == RMAX) begin
         rcnt <= '0;
         sel  <= sel + 2'd1;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
   end

   assign nib   = bcd_r[4*sel +: 4];
   // A digit is blank when it and every more significant digit are zero; units always shows
   assign blank = (sel != 2'd0) && ((bcd_r >> {sel, 2'b00}) == 16'h0000);
   assign an    = ~(4'b0001 << sel);

   // Active-low segment decode {g,f,e,d,c,b,a} of the selected digit
   always_comb begin
      seg = 7'b1111111;
      if (!blank) begin
         case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
         endcase
      end
   end

   assign bus.bcd  = bcd_r;
   assign bus.done = done_r;
   assign bus.busy = busy_r;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - scoreboard bench for score_display with random scores and an arithmetic reference
module tb_score_display;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg;
   logic [3:0] an;

   score_display_if bus();

   score_display #(.REFRESH_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .seg   (seg),
      .an    (an)
   );

   always #5 clk = ~clk;

   typedef struct {
      int val;
      int at;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   disp_val = 0;
   int   model_shown = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] digit_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int idx, input int v);
      int p = 1;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (idx > 0 && v < p) return 7'b1111111;
      return digit_seg((v / p) % 10);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int an_index(input logic [3:0] a);
      for (int i = 0; i < 4; i++) begin
         if (a == ~(4'b0001 << i)) return i;
      end
      return -1;
   endfunction

   // Monitor: pop an expectation on every done pulse, and check the displayed state every cycle
   always @(negedge clk) begin
      exp_t e;
      int   idx;
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: bcd %h at cycle %0d, required no pulse", bus.bcd, cyc);
         end else begin
            e = sbq.pop_front();
            check("done_bcd", 32'(bus.bcd), 32'(to_bcd(e.val)));
            check("done_cycle", cyc, e.at);
            disp_val = e.val;
         end
      end
      check("bcd_hold", 32'(bus.bcd), 32'(to_bcd(disp_val)));
      idx = an_index(an);
      if (idx < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL an_onehot: got %b, required one active-low digit", an);
      end else begin
         check("seg_digit", 32'(seg), 32'(exp_seg(idx, disp_val)));
      end
   end

   task automatic apply(input int v);
      bus.score = 12'(v);
      if (v != model_shown) begin
         sbq.push_back('{val: v, at: cyc + 14});
         model_shown = v;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL done_timeout: %0d conversions outstanding, required 0", sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   task automatic mid_change(input int a, input int b, input int d);
      int n;
      n = cyc;
      bus.score = 12'(a);
      sbq.push_back('{val: a, at: n + 14});
      repeat (d + 1) @(negedge clk);
      bus.score = 12'(b);
      if (b != a) sbq.push_back('{val: b, at: n + 28});
      model_shown = b;
      wait_idle();
   endtask

   task automatic check_refresh();
      int prev, run, cur;
      bit first;
      prev  = an_index(an);
      run   = 1;
      first = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         cur = an_index(an);
         if (cur == prev) begin
            run++;
         end else begin
            check("an_step", cur, (prev + 1) % 4);
            if (!first) check("an_dwell", run, 4);
            first = 1'b0;
            run   = 1;
            prev  = cur;
         end
      end
   endtask

   initial begin
      int n, m, r, v, b;
      rst_n     = 1'b0;
      bus.score = 12'd0;
      repeat (3) @(negedge clk);
      check("rst_bcd", 32'(bus.bcd), 32'h0);
      check("rst_an", 32'(an), 32'b1110);
      check("rst_seg", 32'(seg), 32'b1000000);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("idle_busy", 32'(bus.busy), 0);

      n = cyc;
      apply(2408);
      check("busy_before", 32'(bus.busy), 0);
      @(negedge clk);
      check("busy_rise", 32'(bus.busy), 1);
      wait_idle();
      check("busy_after", 32'(bus.busy), 0);

      apply(4095);
      wait_idle();
      apply(7);
      wait_idle();
      check_refresh();

      mid_change(2408, 100, 5);

      apply(1234);
      wait_idle();
      check_refresh();

      bus.score = 12'd2408;
      repeat (6) @(negedge clk);
      #2;
      rst_n       = 1'b0;
      disp_val    = 0;
      model_shown = 0;
      #1;
      check("abort_bcd", 32'(bus.bcd), 32'h0);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_done", 32'(bus.done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m = cyc;
      sbq.push_back('{val: 2408, at: m + 14});
      model_shown = 2408;
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 3);
         v = $urandom_range(0, 4095);
         if (v == model_shown) v = (v + 1) % 4096;
         if (r == 0) begin
            bus.score = 12'(model_shown);
            repeat (20) @(negedge clk);
         end else if (r == 1) begin
            b = $urandom_range(0, 4095);
            mid_change(v, b, $urandom_range(1, 12));
         end else begin
            apply(v);
            wait_idle();
         end
      end

      repeat (5) @(negedge clk);
      check("queue_drain", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
